// File: rtl/passcode_ctrl.sv
// Doorlock passcode controller: assembles BCD digits from the keypad, checks them against a
// stored code, and drives unlock, error, save and lockout indications.
module passcode_ctrl #(
    parameter int unsigned         PW_LEN         = 4,
    parameter logic [4*PW_LEN-1:0] DEFAULT_PW     = 16'h1234,
    parameter int unsigned         OPEN_CYCLES    = 1000,
    parameter int unsigned         MAX_FAIL       = 3,
    parameter int unsigned         LOCKOUT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       input_v,
    input  logic [3:0] index,
    input  logic       enter_v,
    input  logic       set_req,
    output logic       unlocked,
    output logic       err_p,
    output logic       saved_p,
    output logic       locked_out,
    output logic [2:0] digit_cnt
);

    localparam int unsigned BW = 4 * PW_LEN;
    localparam int unsigned FW = $clog2(MAX_FAIL + 1);

    localparam logic [2:0]    PW_CNT    = 3'(PW_LEN);
    localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_FAIL);
    localparam logic [31:0]   OPEN_LOAD = 32'(OPEN_CYCLES);
    localparam logic [31:0]   LOCK_LOAD = 32'(LOCKOUT_CYCLES);

    typedef enum logic [1:0] {
        StEntry,
        StOpen,
        StSet,
        StLockout
    } state_e;

    state_e        state_q;
    logic [BW-1:0] buf_q;
    logic [BW-1:0] stored_q;
    logic [2:0]    cnt_q;
    logic [FW-1:0] fail_q;
    logic [31:0]   timer_q;
    logic          unlocked_q;
    logic          err_q;
    logic          saved_q;
    logic          locked_q;

    logic [BW-1:0] buf_shift;
    logic          digit_ok;
    logic          code_match;
    logic [FW-1:0] fail_inc;

    always_comb begin
        buf_shift      = buf_q << 4;
        buf_shift[3:0] = index;
        digit_ok       = input_v && (index <= 4'd9) && (cnt_q < PW_CNT);
        code_match     = (cnt_q == PW_CNT) && (buf_q == stored_q);
        fail_inc       = (fail_q == FAIL_MAX) ? fail_q : fail_q + FW'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StEntry;
            buf_q      <= '0;
            stored_q   <= DEFAULT_PW;
            cnt_q      <= '0;
            fail_q     <= '0;
            timer_q    <= '0;
            unlocked_q <= 1'b0;
            err_q      <= 1'b0;
            saved_q    <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            err_q   <= 1'b0;
            saved_q <= 1'b0;
            case (state_q)
                StEntry: begin
                    // enter_v takes priority over a digit arriving in the same cycle
                    if (enter_v) begin
                        buf_q <= '0;
                        cnt_q <= '0;
                        if (code_match) begin
                            state_q    <= StOpen;
                            unlocked_q <= 1'b1;
                            fail_q     <= '0;
                            timer_q    <= OPEN_LOAD;
                        end else begin
                            err_q  <= 1'b1;
                            fail_q <= fail_inc;
                            if (fail_inc == FAIL_MAX) begin
                                state_q  <= StLockout;
                                locked_q <= 1'b1;
                                timer_q  <= LOCK_LOAD;
                            end
                        end
                    end else if (digit_ok) begin
                        buf_q <= buf_shift;
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                StOpen: begin
                    if (enter_v && set_req) begin
                        state_q <= StSet;
                        buf_q   <= '0;
                        cnt_q   <= '0;
                    end else if (timer_q <= 32'd1) begin
                        state_q    <= StEntry;
                        unlocked_q <= 1'b0;
                        timer_q    <= '0;
                    end else begin
                        timer_q <= timer_q - 32'd1;
                    end
                end
                StSet: begin
                    if (enter_v) begin
                        state_q    <= StEntry;
                        unlocked_q <= 1'b0;
                        buf_q      <= '0;
                        cnt_q      <= '0;
                        if (cnt_q == PW_CNT) begin
                            stored_q <= buf_q;
                            saved_q  <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end else if (digit_ok) begin
                        buf_q <= buf_shift;
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                StLockout: begin
                    if (timer_q <= 32'd1) begin
                        state_q  <= StEntry;
                        locked_q <= 1'b0;
                        fail_q   <= '0;
                        timer_q  <= '0;
                    end else begin
                        timer_q <= timer_q - 32'd1;
                    end
                end
                default: state_q <= StEntry;
            endcase
        end
    end

    assign unlocked   = unlocked_q;
    assign err_p      = err_q;
    assign saved_p    = saved_q;
    assign locked_out = locked_q;
    assign digit_cnt  = cnt_q;

endmodule

// File: tb/tb_passcode_ctrl.sv
// Directed, table-driven bench for passcode_ctrl with short open/lockout windows.
module tb_passcode_ctrl;

    localparam int unsigned PW_LEN         = 4;
    localparam int unsigned OPEN_CYCLES    = 10;
    localparam int unsigned MAX_FAIL       = 3;
    localparam int unsigned LOCKOUT_CYCLES = 20;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       input_v = 1'b0;
    logic [3:0] index = 4'd0;
    logic       enter_v = 1'b0;
    logic       set_req = 1'b0;
    logic       unlocked;
    logic       err_p;
    logic       saved_p;
    logic       locked_out;
    logic [2:0] digit_cnt;

    passcode_ctrl #(
        .PW_LEN        (PW_LEN),
        .DEFAULT_PW    (16'h1234),
        .OPEN_CYCLES   (OPEN_CYCLES),
        .MAX_FAIL      (MAX_FAIL),
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .input_v   (input_v),
        .index     (index),
        .enter_v   (enter_v),
        .set_req   (set_req),
        .unlocked  (unlocked),
        .err_p     (err_p),
        .saved_p   (saved_p),
        .locked_out(locked_out),
        .digit_cnt (digit_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [3:0] idx;
        logic       ev;
        logic       sr;
        logic [6:0] exp;
        string      name;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_pass = 0;

    logic [6:0] outs;
    assign outs = {unlocked, err_p, saved_p, locked_out, digit_cnt};

    function automatic logic [6:0] pk(logic u, logic e, logic s, logic l, logic [2:0] c);
        return {u, e, s, l, c};
    endfunction

    function automatic void add(logic iv, logic [3:0] idx, logic ev, logic sr, logic [6:0] exp,
                                string name);
        vec_t v;
        v.iv   = iv;
        v.idx  = idx;
        v.ev   = ev;
        v.sr   = sr;
        v.exp  = exp;
        v.name = name;
        tbl.push_back(v);
    endfunction

    // Digits taken from the top nibble down; digit_cnt expected to count 1..n.
    function automatic void add_digits(logic [15:0] code, int n, logic u, string name);
        for (int i = 0; i < n; i++) begin
            add(1'b1, code[15-4*i -: 4], 1'b0, 1'b0, pk(u, 1'b0, 1'b0, 1'b0, 3'(i + 1)), name);
        end
    endfunction

    function automatic void add_idle(int n, logic u, logic l, logic [2:0] c, string name);
        for (int i = 0; i < n; i++) begin
            add(1'b0, 4'd0, 1'b0, 1'b0, pk(u, 1'b0, 1'b0, l, c), name);
        end
    endfunction

    task automatic check(string name, logic [6:0] got, logic [6:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got unl/err/sav/lck/cnt=%b_%b_%b_%b_%0d want %b_%b_%b_%b_%0d",
                     name, got[6], got[5], got[4], got[3], got[2:0],
                     exp[6], exp[5], exp[4], exp[3], exp[2:0]);
        end
    endtask

    task automatic run_table();
        foreach (tbl[i]) begin
            @(negedge clk);
            input_v = tbl[i].iv;
            index   = tbl[i].idx;
            enter_v = tbl[i].ev;
            set_req = tbl[i].sr;
            @(posedge clk);
            #1;
            check($sformatf("%s[%0d]", tbl[i].name, i), outs, tbl[i].exp);
        end
        input_v = 1'b0;
        index   = 4'd0;
        enter_v = 1'b0;
        set_req = 1'b0;
        tbl.delete();
    endtask

    initial begin
        #12;
        check("reset", outs, 7'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Correct code, ignored inputs while open, exact open window
        add_digits(16'h1234, 4, 1'b0, "ok_dig");
        add(1'b0, 4'd0, 1'b1, 1'b0, pk(1, 0, 0, 0, 0), "ok_enter");
        add(1'b1, 4'd5, 1'b0, 1'b0, pk(1, 0, 0, 0, 0), "open_digit");
        add(1'b0, 4'd0, 1'b1, 1'b0, pk(1, 0, 0, 0, 0), "open_enter_noset");
        add_idle(7, 1'b1, 1'b0, 3'd0, "open_hold");
        add_idle(1, 1'b0, 1'b0, 3'd0, "open_expire");
        // Wrong code
        add_digits(16'h1235, 4, 1'b0, "bad_dig");
        add(1'b0, 4'd0, 1'b1, 1'b0, pk(0, 1, 0, 0, 0), "bad_enter");
        add_idle(1, 1'b0, 1'b0, 3'd0, "err_single");
        // Partial entry
        add_digits(16'h1230, 3, 1'b0, "part_dig");
        add(1'b0, 4'd0, 1'b1, 1'b0, pk(0, 1, 0, 0, 0), "part_enter");
        add_idle(1, 1'b0, 1'b0, 3'd0, "part_idle");
        // Filtering: fifth digit and index=F ignored
        add_digits(16'h1234, 4, 1'b0, "filt_dig");
        add(1'b1, 4'd9, 1'b0, 1'b0, pk(0, 0, 0, 0, 4), "filt_extra");
        add(1'b1, 4'hF, 1'b0, 1'b0, pk(0, 0, 0, 0, 4), "filt_nodigit");
        add(1'b0, 4'd0, 1'b1, 1'b0, pk(1, 0, 0, 0, 0), "filt_enter");
        add_idle(9, 1'b1, 1'b0, 3'd0, "filt_open");
        add_idle(1, 1'b0, 1'b0, 3'd0, "filt_expire");
        // Digit together with enter: enter wins
        add_digits(16'h1230, 3, 1'b0, "sim_dig");
        add(1'b1, 4'd4, 1'b1, 1'b0, pk(0, 1, 0, 0, 0), "sim_enter");
        add_idle(1, 1'b0, 1'b0, 3'd0, "sim_idle");
        // Two more failures reach MAX_FAIL
        add_digits(16'h9999, 4, 1'b0, "lk_dig1");
        add(1'b0, 4'd0, 1'b1, 1'b0, pk(0, 1, 0, 0, 0), "lk_enter1");
        add_idle(1, 1'b0, 1'b0, 3'd0, "lk_idle1");
        add_digits(16'h1111, 4, 1'b0, "lk_dig2");
        add(1'b0, 4'd0, 1'b1, 1'b0, pk(0, 1, 0, 1, 0), "lk_start");
        for (int i = 1; i <= 4; i++) begin
            add(1'b1, 4'(i), 1'b0, 1'b0, pk(0, 0, 0, 1, 0), "lk_ign_dig");
        end
        add(1'b0, 4'd0, 1'b1, 1'b0, pk(0, 0, 0, 1, 0), "lk_ign_enter");
        add_idle(14, 1'b0, 1'b1, 3'd0, "lk_hold");
        add_idle(1, 1'b0, 1'b0, 3'd0, "lk_expire");
        add_digits(16'h1234, 4, 1'b0, "post_lk_dig");
        add(1'b0, 4'd0, 1'b1, 1'b0, pk(1, 0, 0, 0, 0), "post_lk_unlock");
        run_table();

        // Code change while open; SET does not time out
        add(1'b0, 4'd0, 1'b1, 1'b1, pk(1, 0, 0, 0, 0), "set_enter");
        add_digits(16'h5678, 4, 1'b1, "set_dig");
        add_idle(12, 1'b1, 1'b0, 3'd4, "set_hold");
        add(1'b0, 4'd0, 1'b1, 1'b0, pk(0, 0, 1, 0, 0), "set_save");
        add_idle(1, 1'b0, 1'b0, 3'd0, "saved_pulse");
        add_digits(16'h1234, 4, 1'b0, "old_dig");
        add(1'b0, 4'd0, 1'b1, 1'b0, pk(0, 1, 0, 0, 0), "old_rejected");
        add_idle(1, 1'b0, 1'b0, 3'd0, "old_idle");
        add_digits(16'h5678, 4, 1'b0, "new_dig");
        add(1'b0, 4'd0, 1'b1, 1'b0, pk(1, 0, 0, 0, 0), "new_ok");
        // Short SET entry is rejected and leaves the code alone
        add(1'b0, 4'd0, 1'b1, 1'b1, pk(1, 0, 0, 0, 0), "set2_enter");
        add_digits(16'h1200, 2, 1'b1, "set2_dig");
        add(1'b0, 4'd0, 1'b1, 1'b0, pk(0, 1, 0, 0, 0), "set_short");
        add_idle(1, 1'b0, 1'b0, 3'd0, "set_short_idle");
        add_digits(16'h5678, 4, 1'b0, "kept_dig");
        add(1'b0, 4'd0, 1'b1, 1'b0, pk(1, 0, 0, 0, 0), "kept_code");
        run_table();

        // Asynchronous reset while open, away from any clock edge
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("async_reset", outs, 7'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;

        add_digits(16'h5678, 4, 1'b0, "reverted_dig");
        add(1'b0, 4'd0, 1'b1, 1'b0, pk(0, 1, 0, 0, 0), "reverted");
        add_idle(1, 1'b0, 1'b0, 3'd0, "reverted_idle");
        add_digits(16'h1234, 4, 1'b0, "default_dig");
        add(1'b0, 4'd0, 1'b1, 1'b0, pk(1, 0, 0, 0, 0), "default_ok");
        add_idle(9, 1'b1, 1'b0, 3'd0, "default_open");
        add_idle(1, 1'b0, 1'b0, 3'd0, "default_expire");
        run_table();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/passcode_ctrl.md
Name: passcode_ctrl

Overview:
Doorlock passcode controller sitting directly downstream of the keypad button register. Consumes its one-cycle digit-valid pulse and 4-bit digit index, assembles a BCD passcode, and compares it against a stored code on an enter pulse. Drives unlock, error and lockout indications, and supports changing the stored code while unlocked.

Parameters:
PW_LEN, 4, passcode length in digits; legal range 1..7.
DEFAULT_PW, 16'h1234, reset value of the stored code, BCD, width 4*PW_LEN.
OPEN_CYCLES, 1000, clock cycles the lock stays open.
MAX_FAIL, 3, consecutive failed attempts that trigger lockout; must be at least 1.
LOCKOUT_CYCLES, 5000, clock cycles of lockout.

Ports:
clk  in  1  system clock, rising edge.
rstn  in  1  asynchronous active-low reset.
input_v  in  1  one-cycle digit-valid pulse from the button register.
index  in  4  digit 0..9; values 10..15 mean no digit.
enter_v  in  1  one-cycle confirm pulse.
set_req  in  1  level; sampled at enter_v while OPEN to request a code change.
unlocked  out  1  door open; also high during SET.
err_p  out  1  one-cycle pulse on a failed entry or a failed set.
saved_p  out  1  one-cycle pulse when a new code is stored.
locked_out  out  1  high during LOCKOUT.
digit_cnt  out  3  number of digits currently buffered.

Behaviour:
- Clock and reset: single clock clk; rstn is asynchronous and active-low.
- Reset values:
  - state = ENTRY; entry buffer, digit_cnt, fail_cnt and timer = 0.
  - stored code = DEFAULT_PW.
  - All outputs = 0.
- Register timing: all outputs are registered and update on the clk edge after the sampling edge.
- Digit capture (ENTRY and SET only):
  - Condition: input_v=1, index<=9 and digit_cnt<PW_LEN.
  - Shift: buf <= {buf[4*PW_LEN-5:0], index}; digit_cnt increments.
  - Ignored: digits beyond PW_LEN, and index>9.
- Priority: if input_v and enter_v are high in the same cycle, enter_v wins and the digit is discarded.
- ENTRY, on enter_v:
  - digit_cnt==PW_LEN and buf==stored: go to OPEN; unlocked=1; fail_cnt=0; timer loads OPEN_CYCLES.
  - Otherwise: err_p pulse; fail_cnt+1. If the new fail_cnt==MAX_FAIL, go to LOCKOUT with timer=LOCKOUT_CYCLES; else stay in ENTRY.
  - Buffer and digit_cnt clear in every case.
- OPEN:
  - Timer decrements every cycle. When it reaches 1, go to ENTRY; unlocked=0 on the following edge, so unlocked is high for exactly OPEN_CYCLES cycles.
  - Digits are ignored.
  - enter_v with set_req=1: go to SET and clear the buffer; timer stops.
  - enter_v with set_req=0: ignored.
- SET:
  - unlocked stays 1; digits are captured as in ENTRY.
  - On enter_v with digit_cnt==PW_LEN: stored <= buf; saved_p pulse; go to ENTRY; unlocked=0.
  - On enter_v with digit_cnt<PW_LEN: err_p pulse; stored unchanged; go to ENTRY; unlocked=0; fail_cnt unaffected.
- LOCKOUT:
  - locked_out=1; all inputs ignored.
  - Timer counts down. At expiry: go to ENTRY; locked_out=0; fail_cnt=0.
- Timer width: 32 bits.
- fail_cnt saturation: saturates at MAX_FAIL.
- err_p and saved_p: never high together; each is high for one cycle only.
- Reset mid-operation: an immediate return to reset values from any state. A code changed in SET reverts to DEFAULT_PW.

Test Plan (PW_LEN=4, OPEN_CYCLES=10, LOCKOUT_CYCLES=20, MAX_FAIL=3):
- Correct code: digits 1,2,3,4 then enter_v -> unlocked=1 for exactly 10 cycles; digit_cnt goes 1..4, then 0.
- Wrong code: 1,2,3,5 then enter_v -> err_p one cycle; unlocked stays 0. Three wrong entries -> locked_out=1 for 20 cycles. A correct code entered during lockout is ignored; after lockout, 1234 unlocks.
- Partial entry and filtering: 1,2,3 then enter_v -> err_p. Digits 1,2,3,4,9 and index=4'hF pulses -> the 9 and the F are ignored; enter_v unlocks.
- Code change: unlock with 1234, then enter_v with set_req=1, digits 5,6,7,8, enter_v -> saved_p pulse; unlocked=0. Afterwards 1234 -> err_p; 5678 -> unlock.
- Simultaneous events: enter 1,2,3, then input_v(index=4) together with enter_v -> err_p; buffer cleared.
- Reset behaviour: assert rstn low during OPEN after a code change -> all outputs 0 asynchronously; 1234 unlocks after release.
